alu_seq: RTL

- Parametrised, registered successor to the PIC16 core ALU: DATA_W-wide datapath, registered outputs, start/done handshake.
- Adds rotate through a real carry-in, PIC-correct borrow semantics on subtract, and iterative multiply and divide.
- Sits between the W/regfile operand muxes and the STATUS/regfile writeback. The execute FSM issues `start` and waits for `done`.

---
 rtl/alu_seq.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Registered PIC16-style ALU with start/done handshake and optional iterative MUL/DIV.
// Define ALU_SEQ_MULDIV_EN to build the shift-add multiplier and restoring divider.
module alu_seq #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] op_w,
    input  logic [DATA_W-1:0] op_lf,
    input  logic              carry_in,
    input  logic              status_wr_en,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] alu_out_hi,
    output logic              alu_out_z,
    output logic              alu_out_dc,
    output logic              alu_out_c,
    output logic              alu_out_z_wr_en,
    output logic              alu_out_dc_wr_en,
    output logic              alu_out_c_wr_en,
    output logic              div_by_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
`ifdef ALU_SEQ_MULDIV_EN
    localparam logic [1:0] S_RUN  = 2'd1;
`endif
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [3:0] OP_ADD = 4'd0,  OP_AND  = 4'd1,  OP_CLR   = 4'd2,  OP_COM   = 4'd3;
    localparam logic [3:0] OP_DEC = 4'd4,  OP_INC  = 4'd5,  OP_OR    = 4'd6,  OP_PASSLF = 4'd7;
    localparam logic [3:0] OP_PASSW = 4'd8, OP_RLF = 4'd9,  OP_RRF   = 4'd10, OP_SUB   = 4'd11;
    localparam logic [3:0] OP_SWAPF = 4'd12, OP_XOR = 4'd13, OP_MUL  = 4'd14, OP_DIV   = 4'd15;
    localparam int H = DATA_W / 2;

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_out, r_out_hi;
    logic              r_z, r_dc, r_c, r_z_we, r_dc_we, r_c_we, r_dbz;

    logic [DATA_W:0]   w_sum, w_diff;
    logic [4:0]        w_nib_sum, w_nib_diff;
    logic [DATA_W-1:0] w_res;
    logic              w_z, w_dc, w_c, w_zs, w_dcs, w_cs;

    assign w_sum      = {1'b0, op_lf} + {1'b0, op_w};
    assign w_diff     = {1'b0, op_lf} - {1'b0, op_w};
    assign w_nib_sum  = {1'b0, op_lf[3:0]} + {1'b0, op_w[3:0]};
    assign w_nib_diff = {1'b0, op_lf[3:0]} - {1'b0, op_w[3:0]};

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        w_res = '0;
        w_dc  = 1'b0;
        w_c   = 1'b0;
        w_zs  = 1'b1;
        w_dcs = 1'b0;
        w_cs  = 1'b0;
        case (op)
            OP_ADD:    begin w_res = w_sum[DATA_W-1:0]; w_dc = w_nib_sum[4]; w_c = w_sum[DATA_W];
                             w_dcs = 1'b1; w_cs = 1'b1; end
            OP_SUB:    begin w_res = w_diff[DATA_W-1:0]; w_dc = ~w_nib_diff[4]; w_c = ~w_diff[DATA_W];
                             w_dcs = 1'b1; w_cs = 1'b1; end
            OP_AND:    w_res = op_lf & op_w;
            OP_OR:     w_res = op_lf | op_w;
            OP_XOR:    w_res = op_lf ^ op_w;
            OP_COM:    w_res = ~op_lf;
            OP_DEC:    w_res = op_lf - 1'b1;
            OP_INC:    w_res = op_lf + 1'b1;
            OP_PASSLF: w_res = op_lf;
            OP_PASSW:  w_res = op_w;
            OP_CLR:    w_res = '0;
            OP_RLF:    begin w_res = {op_lf[DATA_W-2:0], carry_in}; w_c = op_lf[DATA_W-1];
                             w_zs = 1'b0; w_cs = 1'b1; end
            OP_RRF:    begin w_res = {carry_in, op_lf[DATA_W-1:1]}; w_c = op_lf[0];
                             w_zs = 1'b0; w_cs = 1'b1; end
            OP_SWAPF:  begin w_res = {op_lf[H-1:0], op_lf[DATA_W-1:H]}; w_zs = 1'b0; end
            default:   w_zs = 1'b0;
        endcase
    end

    assign w_z = (w_res == '0);

`ifdef ALU_SEQ_MULDIV_EN
    logic [DATA_W-1:0] r_hi, r_lo, r_b;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_is_div;

    logic [DATA_W:0]   w_mul_sum, w_rem_sh;
    logic [DATA_W-1:0] w_rem_sub, w_hi_nx, w_lo_nx;
    logic              w_ge;

    // Multiply shifts the product right through {hi,lo}; divide shifts the dividend left into hi.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_rem_sh  = {r_hi, r_lo[DATA_W-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_b});
    assign w_rem_sub = w_rem_sh[DATA_W-1:0] - r_b;
    assign w_hi_nx   = r_is_div ? (w_ge ? w_rem_sub : w_rem_sh[DATA_W-1:0]) : w_mul_sum[DATA_W:1];
    assign w_lo_nx   = r_is_div ? {r_lo[DATA_W-2:0], w_ge} : {w_mul_sum[0], r_lo[DATA_W-1:1]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_out    <= '0;
            r_out_hi <= '0;
            r_z      <= 1'b0;
            r_dc     <= 1'b0;
            r_c      <= 1'b0;
            r_z_we   <= 1'b0;
            r_dc_we  <= 1'b0;
            r_c_we   <= 1'b0;
            r_dbz    <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
`ifdef ALU_SEQ_MULDIV_EN
                    if (op == OP_MUL || op == OP_DIV) begin
                        r_state  <= S_RUN;
                        r_cnt    <= CNT_W'(DATA_W);
                        r_hi     <= '0;
                        r_lo     <= op_lf;
                        r_b      <= op_w;
                        r_is_div <= (op == OP_DIV);
                        r_z_we   <= status_wr_en;
                        r_dc_we  <= 1'b0;
                        r_c_we   <= 1'b0;
                        r_dbz    <= (op == OP_DIV) && (op_w == '0);
                    end else
`endif
                    begin
                        r_state  <= S_FIN;
                        r_out    <= w_res;
                        r_out_hi <= '0;
                        r_z      <= w_z;
                        r_dc     <= w_dc;
                        r_c      <= w_c;
                        r_z_we   <= w_zs & status_wr_en;
                        r_dc_we  <= w_dcs & status_wr_en;
                        r_c_we   <= w_cs & status_wr_en;
                        r_dbz    <= 1'b0;
                    end
                end
`ifdef ALU_SEQ_MULDIV_EN
                S_RUN: begin
                    r_hi  <= w_hi_nx;
                    r_lo  <= w_lo_nx;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state  <= S_FIN;
                        r_out    <= w_lo_nx;
                        r_out_hi <= w_hi_nx;
                        r_z      <= r_is_div ? (w_lo_nx == '0) : ({w_hi_nx, w_lo_nx} == '0);
                    end
                end
`endif
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy             = (r_state != S_IDLE);
    assign done             = (r_state == S_FIN);
    assign alu_out          = r_out;
    assign alu_out_hi       = r_out_hi;
    assign alu_out_z        = r_z;
    assign alu_out_dc       = r_dc;
    assign alu_out_c        = r_c;
    assign alu_out_z_wr_en  = r_z_we & done;
    assign alu_out_dc_wr_en = r_dc_we & done;
    assign alu_out_c_wr_en  = r_c_we & done;
    assign div_by_zero      = r_dbz & done;

endmodule
